// File: rtl/hd63701_ram_arbiter.sv
// ---------------------------------------------------------------------------
// hd63701_ram_arbiter
//
// Purpose:
//   Owns the 128x8 internal work RAM ($0080-$00FF) of the HD63701 and shares
//   it between the CPU core and a host/debug port (loader, monitor, ...).
//   The core always wins and is never stalled; the host is served on any
//   cycle where the core does not address the RAM.  The host talks through a
//   4-phase req/ack handshake, so each request produces exactly one access.
//
// Ports:
//   mcu_clx2     in   1   clock
//   mcu_rst_n    in   1   asynchronous active-low reset
//   mcu_ad       in  16   core address
//   mcu_wr       in   1   core write strobe (1 = write)
//   mcu_do       in   8   core write data
//   en_biram     out  1   core address hits $0080-$00FF (combinational)
//   biramd       out  8   registered core read data (1 clock latency)
//   host_req     in   1   host request level (4-phase)
//   host_we      in   1   host write (1) / read (0), stable with req
//   host_addr    in   7   host RAM offset, stable with req
//   host_wdata   in   8   host write data, stable with req
//   host_ack     out  1   one-cycle completion pulse
//   host_rdata   out  8   host read data, valid from ack to next read
//   host_starve  out  1   current request waited STARVE_LIMIT cycles or more
//   host_err     out  1   host write rejected by protection, valid with ack
//
// Configuration:
//   HD63701_RAM_ARB_WP_EN  when defined, host writes to offsets >= WP_BASE
//                          are acknowledged but dropped and flag host_err.
//                          When undefined, host_err is tied low.
// ---------------------------------------------------------------------------
module hd63701_ram_arbiter #(
    parameter int unsigned STARVE_LIMIT = 64
`ifdef HD63701_RAM_ARB_WP_EN
    ,
    parameter logic [6:0]  WP_BASE      = 7'h70
`endif
) (
    input  logic        mcu_clx2,
    input  logic        mcu_rst_n,
    input  logic [15:0] mcu_ad,
    input  logic        mcu_wr,
    input  logic [7:0]  mcu_do,
    output logic        en_biram,
    output logic [7:0]  biramd,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [6:0]  host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        host_starve,
    output logic        host_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;
    localparam logic [1:0] ST_REL  = 2'd3;

    localparam logic [7:0] LIMIT8  = 8'(STARVE_LIMIT);

    logic [7:0] mem [128];

    logic [1:0] state_q,      state_d;
    logic       hostWe_q,     hostWe_d;
    logic [6:0] hostAddr_q,   hostAddr_d;
    logic [7:0] hostWdata_q,  hostWdata_d;
    logic [7:0] waitCnt_q,    waitCnt_d;
    logic       starve_q,     starve_d;
    logic [7:0] biramd_q;
    logic [7:0] hostRdata_q;

    logic hostAccess;
    logic hostBlocked;
    logic hostWrite;

    assign en_biram = (mcu_ad[15:7] == 9'b000000001);

    // The host only touches the RAM in PEND on a cycle the core leaves free,
    // so the two ports can never collide on the same edge.
    assign hostAccess = (state_q == ST_PEND) && !en_biram;
    assign hostWrite  = hostAccess && hostWe_q && !hostBlocked;

`ifdef HD63701_RAM_ARB_WP_EN
    logic err_q;

    assign hostBlocked = (hostAddr_q >= WP_BASE);

    // Error flag is live only for the ACK cycle that follows the access.
    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= hostAccess && hostWe_q && hostBlocked;
        end
    end

    assign host_err = err_q;
`else
    assign hostBlocked = 1'b0;
    assign host_err    = 1'b0;
`endif

    // Memory array has no reset: contents survive a reset of the arbiter.
    always_ff @(posedge mcu_clx2) begin
        if (en_biram && mcu_wr) begin
            mem[mcu_ad[6:0]] <= mcu_do;
        end else if (hostWrite) begin
            mem[hostAddr_q] <= hostWdata_q;
        end
    end

    // Host handshake: capture in IDLE, wait in PEND while the core owns the
    // RAM, pulse ack for one cycle, then hold in REL until req drops so a
    // level that stays high cannot trigger a second access.
    always_comb begin
        state_d     = state_q;
        hostWe_d    = hostWe_q;
        hostAddr_d  = hostAddr_q;
        hostWdata_d = hostWdata_q;
        waitCnt_d   = waitCnt_q;
        starve_d    = starve_q;

        case (state_q)
            ST_IDLE: begin
                if (host_req) begin
                    hostWe_d    = host_we;
                    hostAddr_d  = host_addr;
                    hostWdata_d = host_wdata;
                    waitCnt_d   = 8'h00;
                    state_d     = ST_PEND;
                end
            end
            ST_PEND: begin
                // Sticky once reached; released only when leaving ACK.
                if (waitCnt_q == LIMIT8) begin
                    starve_d = 1'b1;
                end
                if (en_biram) begin
                    if (waitCnt_q != 8'hFF) begin
                        waitCnt_d = waitCnt_q + 8'h01;
                    end
                end else begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                starve_d = 1'b0;
                state_d  = ST_REL;
            end
            ST_REL: begin
                if (!host_req) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers and both read-data ports.
    always_ff @(posedge mcu_clx2 or negedge mcu_rst_n) begin
        if (!mcu_rst_n) begin
            state_q     <= ST_IDLE;
            hostWe_q    <= 1'b0;
            hostAddr_q  <= 7'h00;
            hostWdata_q <= 8'h00;
            waitCnt_q   <= 8'h00;
            starve_q    <= 1'b0;
            biramd_q    <= 8'h00;
            hostRdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            hostWe_q    <= hostWe_d;
            hostAddr_q  <= hostAddr_d;
            hostWdata_q <= hostWdata_d;
            waitCnt_q   <= waitCnt_d;
            starve_q    <= starve_d;
            if (en_biram && !mcu_wr) begin
                biramd_q <= mem[mcu_ad[6:0]];
            end
            if (hostAccess && !hostWe_q) begin
                hostRdata_q <= mem[hostAddr_q];
            end
        end
    end

    assign biramd      = biramd_q;
    assign host_ack    = (state_q == ST_ACK);
    assign host_rdata  = hostRdata_q;
    assign host_starve = starve_q;

endmodule
